fb_fill_engine: RTL and testbench

- Hardware rectangle-free span fill for the 400x300, 8-bit color-index framebuffer.
- Writes a run of consecutive pixels with one color index through framebuffer port B.
- Sits between the data bus arbitrator and framebuffer port B.
- Shares the port: display processor accesses always win; the fill proceeds only on cycles the display processor leaves free.

---
 rtl/fb_fill_engine.sv | 175 +++++++++++++++++
 tb/tb_fb_fill_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_fill_engine.sv
// fb_fill_engine
// Span fill for the 400x300 8-bit color-index framebuffer. A fill writes a
// run of consecutive pixels with one color index through framebuffer port B,
// one 32-bit word (4 pixels) per cycle. The display processor shares the
// port and always wins; the fill only advances on cycles it leaves free.
//
// Ports:
//   gpu_clk, reset          clock, synchronous active-high reset
//   cfg_start_pixel/count   fill range, sampled on an accepted start
//   cfg_color               fill color index, sampled on an accepted start
//   start, abort            begin a fill / cancel the running fill
//   busy, done, error       fill running / completion pulse / reject pulse
//   up_*                    display processor side of the port
//   fb_*                    framebuffer port B (1-cycle read latency)
module fb_fill_engine #(
  parameter int          NUM_PIXELS = 120000,
  parameter int          PIX_W      = 17,
  parameter logic [31:0] FB_BASE    = 32'h0
) (
  input  logic             gpu_clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] cfg_start_pixel,
  input  logic [PIX_W-1:0] cfg_pixel_count,
  input  logic [7:0]       cfg_color,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             error,
  input  logic             up_sel,
  input  logic [31:0]      up_address,
  input  logic [31:0]      up_wr_data,
  input  logic [3:0]       up_wr_en,
  output logic [31:0]      up_rd_data,
  output logic [31:0]      fb_address,
  output logic [31:0]      fb_wr_data,
  output logic [3:0]       fb_wr_en,
  input  logic [31:0]      fb_rd_data
);

  localparam int               WORD_W    = PIX_W - 2;
  localparam logic [PIX_W:0]   NUM_PIX_L = (PIX_W+1)'(NUM_PIXELS);

  typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;

  // Byte lanes of the current word that fall inside the span; the first and
  // last word of the run are trimmed, a single-word run is trimmed on both ends.
  function automatic logic [3:0] lane_mask(
    input logic [WORD_W-1:0] cur,
    input logic [WORD_W-1:0] first,
    input logic [WORD_W-1:0] last,
    input logic [1:0]        first_lane,
    input logic [1:0]        last_lane
  );
    logic [3:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i] = ((cur != first) || (2'(i) >= first_lane)) &&
             ((cur != last)  || (2'(i) <= last_lane));
    end
    return m;
  endfunction

  state_t            state_r, state_s;
  logic [WORD_W-1:0] cur_word_r, cur_word_s;
  logic [WORD_W-1:0] first_word_r, first_word_s;
  logic [WORD_W-1:0] last_word_r, last_word_s;
  logic [1:0]        first_lane_r, first_lane_s;
  logic [1:0]        last_lane_r, last_lane_s;
  logic [7:0]        color_r, color_s;
  logic              done_r, done_s;
  logic              error_r, error_s;
  logic [PIX_W:0]    end_s;
  logic [PIX_W-1:0]  last_pix_s;
  logic              fill_drive_s;

  // Next-state logic: start decode/range check in IDLE, word stepping in FILL.
  always_comb begin
    state_s      = state_r;
    cur_word_s   = cur_word_r;
    first_word_s = first_word_r;
    last_word_s  = last_word_r;
    first_lane_s = first_lane_r;
    last_lane_s  = last_lane_r;
    color_s      = color_r;
    done_s       = 1'b0;
    error_s      = 1'b0;
    // One extra bit so start+count cannot wrap before the range check.
    end_s        = {1'b0, cfg_start_pixel} + {1'b0, cfg_pixel_count};
    last_pix_s   = PIX_W'(end_s - {{PIX_W{1'b0}}, 1'b1});
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          if (cfg_pixel_count == {PIX_W{1'b0}}) begin
            done_s = 1'b1;
          end else if (end_s > NUM_PIX_L) begin
            error_s = 1'b1;
          end else begin
            first_word_s = cfg_start_pixel[PIX_W-1:2];
            last_word_s  = last_pix_s[PIX_W-1:2];
            first_lane_s = cfg_start_pixel[1:0];
            last_lane_s  = last_pix_s[1:0];
            color_s      = cfg_color;
            cur_word_s   = cfg_start_pixel[PIX_W-1:2];
            state_s      = FILL;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (abort) begin
          state_s = IDLE;
        end else if (up_sel) begin
          // Display processor owns the port this cycle: hold everything.
          state_s = FILL;
        end else if (cur_word_r == last_word_r) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          cur_word_s = cur_word_r + {{(WORD_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and fill registers; reset drops any fill in progress.
  always_ff @(posedge gpu_clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cur_word_r   <= {WORD_W{1'b0}};
      first_word_r <= {WORD_W{1'b0}};
      last_word_r  <= {WORD_W{1'b0}};
      first_lane_r <= 2'b00;
      last_lane_r  <= 2'b00;
      color_r      <= 8'h00;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      cur_word_r   <= cur_word_s;
      first_word_r <= first_word_s;
      last_word_r  <= last_word_s;
      first_lane_r <= first_lane_s;
      last_lane_r  <= last_lane_s;
      color_r      <= color_s;
      done_r       <= done_s;
      error_r      <= error_s;
    end
  end

  // Port B mux: the fill drives only on free, non-aborted FILL cycles.
  always_comb begin
    fill_drive_s = (state_r == FILL) && !up_sel && !abort;
    fb_address   = up_address;
    fb_wr_data   = up_wr_data;
    fb_wr_en     = 4'b0000;
    if (fill_drive_s) begin
      fb_address = FB_BASE + {{(32-PIX_W){1'b0}}, cur_word_r, 2'b00};
      fb_wr_data = {4{color_r}};
      fb_wr_en   = lane_mask(cur_word_r, first_word_r, last_word_r,
                             first_lane_r, last_lane_r);
    end else begin
      fb_wr_en = up_sel ? up_wr_en : 4'b0000;
    end
  end

  assign busy       = (state_r == FILL);
  assign done       = done_r;
  assign error      = error_r;
  assign up_rd_data = fb_rd_data;

endmodule

// File: tb/tb_fb_fill_engine.sv
// Scoreboard bench for fb_fill_engine: the driver predicts every fill write,
// done pulse and error pulse from the pixel range arithmetic and queues them;
// an independent monitor pops and compares whenever the DUT shows one.
module tb_fb_fill_engine;

  localparam int          NUM_PIXELS = 120000;
  localparam int          PIX_W      = 17;
  localparam logic [31:0] FB_BASE    = 32'h0;

  localparam int K_WR   = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } ev_t;

  logic             gpu_clk = 1'b0;
  logic             reset;
  logic [PIX_W-1:0] cfg_start_pixel;
  logic [PIX_W-1:0] cfg_pixel_count;
  logic [7:0]       cfg_color;
  logic             start, abort;
  logic             busy, done, error;
  logic             up_sel;
  logic [31:0]      up_address, up_wr_data;
  logic [3:0]       up_wr_en;
  logic [31:0]      up_rd_data;
  logic [31:0]      fb_address, fb_wr_data;
  logic [3:0]       fb_wr_en;
  logic [31:0]      fb_rd_data;

  int  n_vec = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;
  ev_t exp_q[$];

  fb_fill_engine #(.NUM_PIXELS(NUM_PIXELS), .PIX_W(PIX_W), .FB_BASE(FB_BASE)) dut (
    .gpu_clk(gpu_clk), .reset(reset),
    .cfg_start_pixel(cfg_start_pixel), .cfg_pixel_count(cfg_pixel_count),
    .cfg_color(cfg_color), .start(start), .abort(abort),
    .busy(busy), .done(done), .error(error),
    .up_sel(up_sel), .up_address(up_address), .up_wr_data(up_wr_data),
    .up_wr_en(up_wr_en), .up_rd_data(up_rd_data),
    .fb_address(fb_address), .fb_wr_data(fb_wr_data), .fb_wr_en(fb_wr_en),
    .fb_rd_data(fb_rd_data)
  );

  always #5 gpu_clk = ~gpu_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expected event for every fill write / done / error seen.
  always @(negedge gpu_clk) begin
    ev_t e;
    if (mon_en) begin
      chk("rd_passthru", up_rd_data, fb_rd_data);
      if (done && error) chk("done_and_error", 32'd1, 32'd0);
      if (up_sel) begin
        chk("up_addr", fb_address, up_address);
        chk("up_data", fb_wr_data, up_wr_data);
        chk("up_wren", {28'd0, fb_wr_en}, {28'd0, up_wr_en});
      end else if (fb_wr_en !== 4'b0000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {28'd0, fb_wr_en}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("write_kind", K_WR, e.kind);
          chk("write_addr", fb_address, e.addr);
          chk("write_mask", {28'd0, fb_wr_en}, {28'd0, e.mask});
          chk("write_data", fb_wr_data, e.data);
        end
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("done_kind", K_DONE, e.kind);
        end
      end
      if (error === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_error", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("error_kind", K_ERR, e.kind);
        end
      end
    end
  end

  task automatic push(input int kind, input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] data);
    ev_t e;
    e.kind = kind; e.addr = addr; e.mask = mask; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      up_sel     = 1'b0;
      up_wr_en   = 4'($urandom);
      up_address = $urandom;
      fb_rd_data = $urandom;
      @(posedge gpu_clk); #1;
    end
  endtask

  // One fill request. stall_cyc forces up_sel on that cycle after start;
  // abort_after / reset_after cancel the fill once that many words are written.
  task automatic run_fill(input int s, input int n, input logic [7:0] c,
                          input int stall_pct, input int stall_cyc,
                          input int abort_after, input int reset_after);
    int first_w, last_w, nw, lim, writes, cyc, end_p;
    bit full, do_abort, do_reset;
    logic [3:0] m;
    end_p = s + n;
    cfg_start_pixel = PIX_W'(s);
    cfg_pixel_count = PIX_W'(n);
    cfg_color       = c;
    start = 1'b1; abort = 1'b0; up_sel = 1'b0;
    fb_rd_data = $urandom;
    if (n == 0 || end_p > NUM_PIXELS) begin
      push((n == 0) ? K_DONE : K_ERR, 32'd0, 4'd0, 32'd0);
      @(posedge gpu_clk); #1;
      start = 1'b0;
      @(negedge gpu_clk);
      chk("rej_busy", {31'd0, busy}, 32'd0);
      chk("rej_done", {31'd0, done}, (n == 0) ? 32'd1 : 32'd0);
      chk("rej_error", {31'd0, error}, (n == 0) ? 32'd0 : 32'd1);
      @(posedge gpu_clk); #1;
      return;
    end
    first_w = s / 4;
    last_w  = (end_p - 1) / 4;
    nw      = last_w - first_w + 1;
    if (abort_after >= nw) abort_after = -1;
    if (reset_after >= nw) reset_after = -1;
    lim  = (abort_after >= 0) ? abort_after : (reset_after >= 0) ? reset_after : nw;
    full = (lim == nw);
    for (int w = first_w; w < first_w + lim; w++) begin
      m = 4'b0000;
      for (int i = 0; i < 4; i++) m[i] = (4*w + i >= s) && (4*w + i < end_p);
      push(K_WR, FB_BASE + 32'(4*w), m, {4{c}});
    end
    if (full) push(K_DONE, 32'd0, 4'd0, 32'd0);
    @(posedge gpu_clk); #1;
    start  = 1'b0;
    writes = 0;
    cyc    = 1;
    while (1) begin
      do_abort = (abort_after >= 0) && (writes == abort_after);
      do_reset = (reset_after >= 0) && (writes == reset_after);
      up_sel     = (cyc == stall_cyc) || do_reset || (int'($urandom_range(99)) < stall_pct);
      up_address = (cyc == stall_cyc) ? 32'h100 : $urandom;
      up_wr_en   = (cyc == stall_cyc) ? 4'b0000 : 4'($urandom);
      up_wr_data = $urandom;
      fb_rd_data = $urandom;
      abort      = do_abort;
      reset      = do_reset;
      // A start while busy must be ignored.
      start           = (cyc == 2);
      cfg_start_pixel = PIX_W'($urandom_range(NUM_PIXELS - 1));
      cfg_pixel_count = PIX_W'($urandom_range(7));
      @(negedge gpu_clk);
      chk("fill_busy", {31'd0, busy}, 32'd1);
      @(posedge gpu_clk); #1;
      start = 1'b0; abort = 1'b0; reset = 1'b0;
      if (do_abort || do_reset) break;
      if (!up_sel) writes++;
      if (writes == nw) break;
      cyc++;
      if (cyc > 2000) begin
        chk("fill_timeout", 32'd1, 32'd0);
        break;
      end
    end
    up_sel = 1'b0; up_wr_en = 4'($urandom);
    @(negedge gpu_clk);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_done", {31'd0, done}, full ? 32'd1 : 32'd0);
    chk("end_error", {31'd0, error}, 32'd0);
    @(posedge gpu_clk); #1;
  endtask

  initial begin
    int s, n, r, ab;
    reset = 1'b1; start = 1'b0; abort = 1'b0; up_sel = 1'b0;
    cfg_start_pixel = '0; cfg_pixel_count = '0; cfg_color = 8'h00;
    up_address = 32'h0; up_wr_data = 32'h0; up_wr_en = 4'hF; fb_rd_data = 32'h0;
    repeat (3) @(posedge gpu_clk);
    #1;
    mon_en = 1'b1;
    @(negedge gpu_clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_wren", {28'd0, fb_wr_en}, 32'd0);
    @(posedge gpu_clk); #1;
    reset = 1'b0;
    idle_cycles(2);

    run_fill(5, 10, 8'hAB, 0, -1, -1, -1);
    run_fill(5, 10, 8'hAB, 0, 2, -1, -1);
    run_fill(6, 1, 8'h3C, 0, -1, -1, -1);
    run_fill(10, 0, 8'h11, 0, -1, -1, -1);
    run_fill(119999, 2, 8'h22, 0, -1, -1, -1);
    run_fill(119998, 2, 8'h5A, 0, -1, -1, -1);
    run_fill(0, 400, 8'h77, 0, -1, 2, -1);
    idle_cycles(2);
    run_fill(0, 400, 8'h99, 0, -1, -1, 3);
    idle_cycles(1);
    run_fill(9, 7, 8'hE1, 0, -1, -1, -1);

    // start together with abort in IDLE does nothing.
    cfg_start_pixel = 17'd4; cfg_pixel_count = 17'd8;
    start = 1'b1; abort = 1'b1;
    @(posedge gpu_clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge gpu_clk);
    chk("start_abort_busy", {31'd0, busy}, 32'd0);
    @(posedge gpu_clk); #1;
    idle_cycles(2);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(9);
      if (r == 0) begin
        s = $urandom_range(NUM_PIXELS - 1); n = 0;
      end else if (r == 1) begin
        s = NUM_PIXELS - 1 - $urandom_range(3);
        n = NUM_PIXELS - s + 1 + $urandom_range(5);
      end else if (r == 2) begin
        n = 1 + $urandom_range(20); s = NUM_PIXELS - n;
      end else begin
        s = $urandom_range(NUM_PIXELS - 1); n = 1 + $urandom_range(40);
        if (s + n > NUM_PIXELS) s = NUM_PIXELS - n;
      end
      ab = ($urandom_range(4) == 0) ? int'($urandom_range(5)) : -1;
      run_fill(s, n, 8'($urandom), 30, -1, ab, -1);
      idle_cycles($urandom_range(2));
    end

    idle_cycles(4);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
